// File: rtl/nios_cpu_mul_seq.sv
// Sequencer around the 3-partial-product multiplier cell: captures a 32x32 request,
// enables the cell for MULT_LATENCY cycles, then folds p1/p2/p3 into the low 32 product bits.
//
// state  | meaning
// IDLE   | ready for a request, cell disabled
// ISSUE  | cell enabled, counting down MULT_LATENCY edges
// COMB   | partial products held by cell, combine into res_data
// DONE   | result presented, waiting for res_ready
module nios_cpu_mul_seq #(
  parameter int MULT_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] E_src1,
  output logic [31:0] E_src2,
  output logic        M_en,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_COMB  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MULT_LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_res;
  logic [2:0]  r_cnt;
  logic        w_accept;
  logic [15:0] w_mid;
  logic [31:0] w_prod;

  assign w_accept = req_valid && req_ready;

  // Cross terms only contribute their low 16 bits once shifted into the upper half
  assign w_mid  = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign w_prod = M_mul_cell_p1 + {w_mid, 16'h0000};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: if (r_cnt == 3'd0) w_next = S_COMB;
      S_COMB:  w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // req_ready is gated by reset so no request looks accepted while reset is held
  always_comb begin
    req_ready = 1'b0;
    M_en      = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = !reset;
      S_ISSUE: M_en      = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src1 <= 32'h0;
      r_src2 <= 32'h0;
      r_res  <= 32'h0;
      r_cnt  <= 3'd0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_src1 <= req_src1;
        r_src2 <= req_src2;
        r_cnt  <= LAT_M1;
      end else if (r_state == S_ISSUE && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (r_state == S_COMB) r_res <= w_prod;
    end
  end

  assign E_src1   = r_src1;
  assign E_src2   = r_src2;
  assign res_data = r_res;

endmodule

// File: tb/tb_nios_cpu_mul_seq.sv
// Bench for nios_cpu_mul_seq: two instances (MULT_LATENCY 1 and 3), each wrapped by a
// behavioural multiplier cell that only shows correct partial products after enough M_en edges.
module tb_nios_cpu_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic [31:0] E_src1    [2];
  logic [31:0] E_src2    [2];
  logic        M_en      [2];
  logic [31:0] p1        [2];
  logic [31:0] p2        [2];
  logic [31:0] p3        [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_data  [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    int cnt = 0;
    bit prev_en = 1'b0;

    nios_cpu_mul_seq #(.MULT_LATENCY(L)) u_dut (
      .clk           (clk),
      .reset         (reset[g]),
      .req_valid     (req_valid[g]),
      .req_ready     (req_ready[g]),
      .req_src1      (req_src1[g]),
      .req_src2      (req_src2[g]),
      .E_src1        (E_src1[g]),
      .E_src2        (E_src2[g]),
      .M_en          (M_en[g]),
      .M_mul_cell_p1 (p1[g]),
      .M_mul_cell_p2 (p2[g]),
      .M_mul_cell_p3 (p3[g]),
      .res_valid     (res_valid[g]),
      .res_ready     (res_ready[g]),
      .res_data      (res_data[g])
    );

    // Cell model: products become valid after L consecutive enabled edges, garbage before
    always_ff @(posedge clk) begin
      if (M_en[g]) cnt <= (prev_en ? cnt : 0) + 1;
      prev_en <= M_en[g];
    end
    assign p1[g] = (cnt >= L) ? {16'h0, E_src1[g][15:0]}  * {16'h0, E_src2[g][15:0]}  : 32'hDEADBEEF;
    assign p2[g] = (cnt >= L) ? {16'h0, E_src1[g][15:0]}  * {16'h0, E_src2[g][31:16]} : 32'hDEADBEEF;
    assign p3[g] = (cnt >= L) ? {16'h0, E_src1[g][31:16]} * {16'h0, E_src2[g][15:0]}  : 32'hDEADBEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    req_src1[k]  = a;
    req_src2[k]  = b;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && t < 20) begin
      tick();
      t++;
    end
    n_tests++;
    if (req_ready[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_timeout inst%0d: req_ready=%b, required 1", k, req_ready[k]);
      req_valid[k] = 1'b0;
      return;
    end
    tick();
    exp_q.push_back(a * b);
    req_valid[k] = 1'b0;
  endtask

  // Waits for the result (counting M_en cycles), optionally backpressures, then retires it.
  task automatic finish_op(input int k, input int bp, output int lat, output int en);
    logic [31:0] d, e1, e2, exp_v;
    int c = 1;
    en = 0;
    res_ready[k] = (bp == 0);
    while (!res_valid[k] && c < 40) begin
      if (M_en[k]) en++;
      tick();
      c++;
    end
    lat = c;
    n_tests++;
    if (res_valid[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL result_timeout inst%0d: res_valid=%b, required 1", k, res_valid[k]);
      return;
    end
    d  = res_data[k];
    e1 = E_src1[k];
    e2 = E_src2[k];
    for (int i = 0; i < bp; i++) begin
      n_tests++;
      if (res_valid[k] !== 1'b1 || res_data[k] !== d || E_src1[k] !== e1 ||
          E_src2[k] !== e2 || req_ready[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc%0d: valid=%b data=%h e1=%h e2=%h ready=%b, required 1 %h %h %h 0",
                 i, res_valid[k], res_data[k], E_src1[k], E_src2[k], req_ready[k], d, e1, e2);
      end
      req_valid[k] = (i == bp / 2);
      req_src1[k]  = 32'hA5A5A5A5;
      req_src2[k]  = 32'h5A5A5A5A;
      tick();
    end
    req_valid[k] = 1'b0;
    res_ready[k] = 1'b1;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
    n_tests++;
    if (res_data[k] !== exp_v) begin
      n_fail++;
      $display("FAIL res_data inst%0d: got %h, required %h", k, res_data[k], exp_v);
    end
    tick();
    res_ready[k] = 1'b0;
    n_tests++;
    if (res_valid[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL res_pulse inst%0d: res_valid=%b after retire, required 0", k, res_valid[k]);
    end
  endtask

  task automatic test_reset();
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    repeat (3) tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (req_ready[k] !== 1'b1 || res_valid[k] !== 1'b0 || M_en[k] !== 1'b0 ||
          E_src1[k] !== 32'h0 || E_src2[k] !== 32'h0 || res_data[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: ready=%b valid=%b en=%b e1=%h e2=%h data=%h, required 1 0 0 0 0 0",
                 k, req_ready[k], res_valid[k], M_en[k], E_src1[k], E_src2[k], res_data[k]);
      end
    end
  endtask

  task automatic test_basic();
    int lat, en;
    start_op(0, 32'd3, 32'd5);
    finish_op(0, 0, lat, en);
    n_tests++;
    if (lat != 3 || en != 1) begin
      n_fail++;
      $display("FAIL basic_timing: latency=%0d en_cycles=%0d, required 3 1", lat, en);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va[3] = '{32'h00012345, 32'hFFFFFFFF, 32'h00010000};
    logic [31:0] vb[3] = '{32'h00000100, 32'hFFFFFFFF, 32'h00010000};
    int lat, en;
    for (int i = 0; i < 3; i++) begin
      start_op(0, va[i], vb[i]);
      finish_op(0, 0, lat, en);
    end
  endtask

  task automatic test_backpressure();
    int lat, en;
    start_op(0, 32'h00001234, 32'h00000010);
    finish_op(0, 5, lat, en);
    n_tests++;
    if (E_src1[0] !== 32'h00001234 || E_src2[0] !== 32'h00000010) begin
      n_fail++;
      $display("FAIL no_capture_when_busy: e1=%h e2=%h, required 00001234 00000010", E_src1[0], E_src2[0]);
    end
  endtask

  task automatic test_latency3();
    int lat, en;
    start_op(1, 32'd7, 32'd9);
    finish_op(1, 0, lat, en);
    n_tests++;
    if (lat != 5 || en != 3) begin
      n_fail++;
      $display("FAIL lat3_timing: latency=%0d en_cycles=%0d, required 5 3", lat, en);
    end
  endtask

  task automatic test_back_to_back();
    int lat, en;
    for (int i = 0; i < 2; i++) begin
      start_op(1, 32'(i + 11), 32'h00030001);
      finish_op(1, 0, lat, en);
    end
  endtask

  task automatic test_reset_mid();
    int lat, en, t;
    start_op(1, 32'h55, 32'h66);
    n_tests++;
    if (M_en[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_en: M_en=%b, required 1", M_en[1]);
    end
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if (req_ready[1] !== 1'b1 || res_valid[1] !== 1'b0 || M_en[1] !== 1'b0 || E_src1[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_issue: ready=%b valid=%b en=%b e1=%h, required 1 0 0 0",
               req_ready[1], res_valid[1], M_en[1], E_src1[1]);
    end
    start_op(0, 32'd9, 32'd9);
    t = 0;
    while (!res_valid[0] && t < 20) begin
      tick();
      t++;
    end
    n_tests++;
    if (res_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL done_reach_timeout: res_valid=%b, required 1", res_valid[0]);
    end
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    #1;
    exp_q.delete();
    n_tests++;
    if (req_ready[0] !== 1'b1 || res_valid[0] !== 1'b0 || M_en[0] !== 1'b0 || res_data[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_done: ready=%b valid=%b en=%b data=%h, required 1 0 0 0",
               req_ready[0], res_valid[0], M_en[0], res_data[0]);
    end
    start_op(0, 32'd2, 32'd2);
    finish_op(0, 0, lat, en);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k]     = 1'b1;
      req_valid[k] = 1'b0;
      req_src1[k]  = 32'h0;
      req_src2[k]  = 32'h0;
      res_ready[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
